main: RTL and testbench

Two-core MSI snooping cache-coherence subsystem. Each core port has a private direct-mapped cache. The caches share one snooping bus and a 256-byte main memory. It sits between two processor-side request interfaces and backing storage, and keeps both caches coherent under the MSI protocol.

---
 rtl/main.sv | 200 ++++++++++++++++++++
 tb/tb_main.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/main.sv
// main: two-core MSI snooping cache-coherence subsystem.
// Each core owns a 4-line direct-mapped cache (1-byte lines, 6-bit tag,
// index = addr[1:0]). Both caches share one snooping bus, which is
// round-robin arbitrated, and a 256-byte write-back main memory.
// Ports:
//   clk                    system clock, rising edge
//   reset                  synchronous active-high reset
//   req0/req1              request strobe, sampled only while that controller is IDLE
//   p_func0/p_func1        1 = write, 0 = read (captured with req)
//   p_addr0/p_addr1        byte address (captured with req)
//   p_data0/p_data1        write data in the request cycle; read data in the ready cycle
//   ready0/ready1          one-cycle completion pulse per request
module main (
  input  logic       clk,
  input  logic       reset,
  input  logic       req0,
  input  logic       req1,
  input  logic       p_func0,
  input  logic       p_func1,
  input  logic [7:0] p_addr0,
  input  logic [7:0] p_addr1,
  inout  logic [7:0] p_data0,
  inout  logic [7:0] p_data1,
  output logic       ready0,
  output logic       ready1
);

  typedef enum logic [1:0] {ST_IDLE, ST_ARB, ST_BUS, ST_RESP} ctl_e;
  typedef enum logic [1:0] {LN_I, LN_S, LN_M} line_e;

  ctl_e       r_cs   [2];
  ctl_e       w_ns   [2];
  line_e      r_lst  [2][4];
  logic [5:0] r_ltag [2][4];
  logic [7:0] r_ldat [2][4];
  logic [7:0] r_mem  [256];
  logic [7:0] r_addr [2];
  logic       r_func [2];
  logic [7:0] r_wdat [2];
  logic [7:0] r_rdat [2];
  logic       r_ptr;

  logic       w_req    [2];
  logic       w_func   [2];
  logic [7:0] w_addr   [2];
  logic [7:0] w_wdat   [2];
  logic       w_hit_rd [2];
  logic       w_hit_wr [2];

  logic       w_gnt_v, w_gnt_id;
  logic       w_bus_v, w_bus_id, w_bus_oth;
  logic [1:0] w_bidx;
  logic [5:0] w_btag;
  logic       w_own_hit, w_own_m, w_snp_hit, w_snp_m;
  logic [7:0] w_snp_dat, w_fill;

  // Processor-side inputs and local hit detection
  always_comb begin
    w_req[0]  = req0;    w_req[1]  = req1;
    w_func[0] = p_func0; w_func[1] = p_func1;
    w_addr[0] = p_addr0; w_addr[1] = p_addr1;
    w_wdat[0] = p_data0; w_wdat[1] = p_data1;
    for (int unsigned c = 0; c < 2; c++) begin
      w_hit_rd[c] = 1'b0;
      w_hit_wr[c] = 1'b0;
      if (r_lst[c][w_addr[c][1:0]] != LN_I &&
          r_ltag[c][w_addr[c][1:0]] == w_addr[c][7:2]) begin
        w_hit_rd[c] = !w_func[c];
        w_hit_wr[c] = w_func[c] && (r_lst[c][w_addr[c][1:0]] == LN_M);
      end
    end
  end

  // Round-robin arbiter: the pointer only matters when both cores wait
  always_comb begin
    w_gnt_v  = 1'b0;
    w_gnt_id = 1'b0;
    if (r_cs[0] == ST_ARB && r_cs[1] == ST_ARB) begin
      w_gnt_v  = 1'b1;
      w_gnt_id = r_ptr;
    end else if (r_cs[0] == ST_ARB) begin
      w_gnt_v  = 1'b1;
    end else if (r_cs[1] == ST_ARB) begin
      w_gnt_v  = 1'b1;
      w_gnt_id = 1'b1;
    end
  end

  // Bus transaction of the (single) controller in BUS, and the snoop of the other cache.
  // The line state is re-examined here rather than at capture, since a transaction by
  // the other core while waiting in ARB may have invalidated an S copy.
  always_comb begin
    w_bus_v   = (r_cs[0] == ST_BUS) || (r_cs[1] == ST_BUS);
    w_bus_id  = (r_cs[1] == ST_BUS);
    w_bus_oth = !w_bus_id;
    w_bidx    = r_addr[w_bus_id][1:0];
    w_btag    = r_addr[w_bus_id][7:2];
    w_own_hit = (r_lst[w_bus_id][w_bidx] != LN_I) && (r_ltag[w_bus_id][w_bidx] == w_btag);
    w_own_m   = (r_lst[w_bus_id][w_bidx] == LN_M);
    w_snp_hit = (r_lst[w_bus_oth][w_bidx] != LN_I) && (r_ltag[w_bus_oth][w_bidx] == w_btag);
    w_snp_m   = w_snp_hit && (r_lst[w_bus_oth][w_bidx] == LN_M);
    // A write hit the other core captures this same cycle is ordered before the bus op
    if (r_cs[w_bus_oth] == ST_IDLE && w_req[w_bus_oth] && w_func[w_bus_oth] &&
        w_addr[w_bus_oth] == r_addr[w_bus_id])
      w_snp_dat = w_wdat[w_bus_oth];
    else
      w_snp_dat = r_ldat[w_bus_oth][w_bidx];
    w_fill = w_snp_m ? w_snp_dat : r_mem[r_addr[w_bus_id]];
  end

  always_comb begin
    for (int unsigned c = 0; c < 2; c++) begin
      w_ns[c] = r_cs[c];
      case (r_cs[c])
        ST_IDLE: if (w_req[c]) w_ns[c] = (w_hit_rd[c] || w_hit_wr[c]) ? ST_RESP : ST_ARB;
        ST_ARB:  if (w_gnt_v && w_gnt_id == 1'(c)) w_ns[c] = ST_BUS;
        ST_BUS:  w_ns[c] = ST_RESP;
        default: w_ns[c] = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cs[0] <= ST_IDLE;
      r_cs[1] <= ST_IDLE;
    end else begin
      r_cs[0] <= w_ns[0];
      r_cs[1] <= w_ns[1];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ptr <= 1'b0;
      for (int unsigned c = 0; c < 2; c++) begin
        r_addr[c] <= '0;
        r_func[c] <= 1'b0;
        r_wdat[c] <= '0;
        r_rdat[c] <= '0;
        for (int unsigned l = 0; l < 4; l++) begin
          r_lst[c][l]  <= LN_I;
          r_ltag[c][l] <= '0;
          r_ldat[c][l] <= '0;
        end
      end
      for (int unsigned a = 0; a < 256; a++) r_mem[a] <= '0;
    end else begin
      for (int unsigned c = 0; c < 2; c++) begin
        if (r_cs[c] == ST_IDLE && w_req[c]) begin
          r_addr[c] <= w_addr[c];
          r_func[c] <= w_func[c];
          r_wdat[c] <= w_wdat[c];
          if (w_hit_rd[c]) r_rdat[c] <= r_ldat[c][w_addr[c][1:0]];
          if (w_hit_wr[c]) r_ldat[c][w_addr[c][1:0]] <= w_wdat[c];
        end
      end

      if (w_gnt_v) r_ptr <= !w_gnt_id;

      if (w_bus_v) begin
        if (w_own_hit) begin
          if (r_func[w_bus_id]) begin
            // BusUpgr
            r_lst[w_bus_id][w_bidx]  <= LN_M;
            r_ldat[w_bus_id][w_bidx] <= r_wdat[w_bus_id];
            if (w_snp_hit) r_lst[w_bus_oth][w_bidx] <= LN_I;
          end else begin
            r_rdat[w_bus_id] <= r_ldat[w_bus_id][w_bidx];
          end
        end else begin
          if (w_own_m)
            r_mem[{r_ltag[w_bus_id][w_bidx], w_bidx}] <= r_ldat[w_bus_id][w_bidx];
          r_ltag[w_bus_id][w_bidx] <= w_btag;
          if (r_func[w_bus_id]) begin
            // BusRdX; a 1-byte line means the merge is a full overwrite
            r_lst[w_bus_id][w_bidx]  <= LN_M;
            r_ldat[w_bus_id][w_bidx] <= r_wdat[w_bus_id];
            if (w_snp_hit) r_lst[w_bus_oth][w_bidx] <= LN_I;
          end else begin
            // BusRd
            r_lst[w_bus_id][w_bidx]  <= LN_S;
            r_ldat[w_bus_id][w_bidx] <= w_fill;
            r_rdat[w_bus_id]         <= w_fill;
            if (w_snp_m) begin
              r_lst[w_bus_oth][w_bidx]  <= LN_S;
              r_mem[r_addr[w_bus_id]]   <= w_snp_dat;
            end
          end
        end
      end
    end
  end

  assign ready0  = (r_cs[0] == ST_RESP);
  assign ready1  = (r_cs[1] == ST_RESP);
  assign p_data0 = (r_cs[0] == ST_RESP && !r_func[0]) ? r_rdat[0] : 'z;
  assign p_data1 = (r_cs[1] == ST_RESP && !r_func[1]) ? r_rdat[1] : 'z;

endmodule

// File: tb/tb_main.sv
// tb_main: scoreboard bench for the two-core MSI cache subsystem.
// The reference model is a flat 256-byte array holding the latest value written
// to each address; a coherent system must return exactly that on every read.
module tb_main;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       req0 = 1'b0, req1 = 1'b0;
  logic       p_func0 = 1'b0, p_func1 = 1'b0;
  logic [7:0] p_addr0 = '0, p_addr1 = '0;
  logic       drv0 = 1'b0, drv1 = 1'b0;
  logic [7:0] d0 = '0, d1 = '0;
  wire  [7:0] p_data0, p_data1;
  logic       ready0, ready1;

  assign p_data0 = drv0 ? d0 : 'z;
  assign p_data1 = drv1 ? d1 : 'z;

  main dut (
    .clk     (clk),
    .reset   (reset),
    .req0    (req0),
    .req1    (req1),
    .p_func0 (p_func0),
    .p_func1 (p_func1),
    .p_addr0 (p_addr0),
    .p_addr1 (p_addr1),
    .p_data0 (p_data0),
    .p_data1 (p_data1),
    .ready0  (ready0),
    .ready1  (ready1)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  typedef struct {
    bit         rd;
    logic [7:0] data;
    int         lat;   // 0 = latency not checked
    int         cap;
  } exp_t;

  exp_t       q0[$], q1[$];
  exp_t       me;
  logic [7:0] model [256];
  int         checks = 0, errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops one expectation per ready pulse
  always @(negedge clk) begin
    if (!reset) begin
      if (ready0) begin
        if (q0.size() == 0) chk("core0 unexpected ready", 1, 0);
        else begin
          me = q0.pop_front();
          if (me.rd) chk("core0 read data", {24'd0, p_data0}, {24'd0, me.data});
          if (me.lat > 0) chk("core0 latency", cyc - me.cap + 1, me.lat);
        end
      end
      if (ready1) begin
        if (q1.size() == 0) chk("core1 unexpected ready", 1, 0);
        else begin
          me = q1.pop_front();
          if (me.rd) chk("core1 read data", {24'd0, p_data1}, {24'd0, me.data});
          if (me.lat > 0) chk("core1 latency", cyc - me.cap + 1, me.lat);
        end
      end
    end
  end

  task automatic issue2(input bit e0, input bit w0, input logic [7:0] a0, input logic [7:0] v0,
                        input int l0, input bit e1, input bit w1, input logic [7:0] a1,
                        input logic [7:0] v1, input int l1);
    exp_t x;
    @(negedge clk);
    req0 = e0; p_func0 = w0; p_addr0 = a0; d0 = v0; drv0 = e0 && w0;
    req1 = e1; p_func1 = w1; p_addr1 = a1; d1 = v1; drv1 = e1 && w1;
    @(posedge clk);
    #1;
    if (e0) begin
      x.rd = !w0; x.data = model[a0]; x.lat = l0; x.cap = cyc;
      q0.push_back(x);
    end
    if (e1) begin
      x.rd = !w1; x.data = model[a1]; x.lat = l1; x.cap = cyc;
      q1.push_back(x);
    end
    if (e0 && w0) model[a0] = v0;
    if (e1 && w1) model[a1] = v1;
    req0 = 1'b0; req1 = 1'b0; drv0 = 1'b0; drv1 = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while ((q0.size() != 0 || q1.size() != 0) && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (q0.size() != 0 || q1.size() != 0) begin
      chk("completion timeout", q0.size() + q1.size(), 0);
      q0.delete();
      q1.delete();
    end
  endtask

  task automatic op(input int c, input bit w, input logic [7:0] a, input logic [7:0] v,
                    input int lat);
    if (c == 0) issue2(1'b1, w, a, v, lat, 1'b0, 1'b0, 8'h00, 8'h00, 0);
    else        issue2(1'b0, 1'b0, 8'h00, 8'h00, 0, 1'b1, w, a, v, lat);
    wait_done();
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    q0.delete();
    q1.delete();
    for (int i = 0; i < 256; i++) model[i] = 8'h00;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] pool [6];
    logic [7:0] a0, a1;
    int         r;
    pool = '{8'h10, 8'h14, 8'h18, 8'h11, 8'h15, 8'h22};

    do_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("reset ready0", {31'd0, ready0}, 0);
      chk("reset ready1", {31'd0, ready1}, 0);
    end

    // Basic miss / upgrade / hit / snoop sequence
    op(0, 1'b0, 8'h10, 8'h00, 3);
    op(0, 1'b1, 8'h10, 8'hA5, 3);
    op(0, 1'b0, 8'h10, 8'h00, 1);
    op(1, 1'b0, 8'h10, 8'h00, 3);
    op(1, 1'b1, 8'h10, 8'h3C, 3);
    op(0, 1'b0, 8'h10, 8'h00, 3);
    op(1, 1'b0, 8'h10, 8'h00, 1);
    op(0, 1'b0, 8'h10, 8'h00, 1);

    // Simultaneous misses and round-robin pointer
    do_reset();
    issue2(1'b1, 1'b0, 8'h20, 8'h00, 3, 1'b1, 1'b0, 8'h31, 8'h00, 4);
    wait_done();
    op(0, 1'b0, 8'h24, 8'h00, 3);
    issue2(1'b1, 1'b0, 8'h28, 8'h00, 4, 1'b1, 1'b0, 8'h35, 8'h00, 3);
    wait_done();

    // Victim write-back and snoop forwarding from M
    op(0, 1'b1, 8'h10, 8'h11, 3);
    op(0, 1'b1, 8'h14, 8'h22, 3);
    op(1, 1'b0, 8'h10, 8'h00, 3);
    op(1, 1'b0, 8'h14, 8'h00, 3);
    op(0, 1'b1, 8'h14, 8'h33, 3);
    op(0, 1'b1, 8'h14, 8'h44, 1);
    op(1, 1'b0, 8'h14, 8'h00, 3);

    // A req while the controller is busy must be ignored
    issue2(1'b1, 1'b0, 8'h40, 8'h00, 3, 1'b0, 1'b0, 8'h00, 8'h00, 0);
    @(negedge clk);
    req0 = 1'b1; p_func0 = 1'b1; p_addr0 = 8'h40; d0 = 8'h99; drv0 = 1'b1;
    @(posedge clk);
    #1;
    req0 = 1'b0; drv0 = 1'b0;
    wait_done();
    repeat (6) @(negedge clk);
    op(0, 1'b0, 8'h40, 8'h00, 1);

    // Reset in the middle of a miss: no ready, contents lost
    issue2(1'b1, 1'b0, 8'h41, 8'h00, 3, 1'b0, 1'b0, 8'h00, 8'h00, 0);
    do_reset();
    repeat (6) @(negedge clk);
    op(0, 1'b0, 8'h14, 8'h00, 3);
    op(1, 1'b0, 8'h10, 8'h00, 3);

    // Randomized traffic on colliding indices; concurrent ops use distinct addresses
    for (int it = 0; it < 200; it++) begin
      a0 = pool[$urandom_range(0, 5)];
      do a1 = pool[$urandom_range(0, 5)]; while (a1 == a0);
      r = $urandom_range(1, 3);
      issue2(r[0], 1'($urandom_range(0, 1)), a0, 8'($urandom), 0,
             r[1], 1'($urandom_range(0, 1)), a1, 8'($urandom), 0);
      wait_done();
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (4) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
